note_playback_scheduler: RTL and testbench
==========================================

# note_playback_scheduler

Sequences the note RAM during playback. It scans the stored note words in address order once per pass and compares each word's start/end timestamps against the running microsecond counter. From that it produces a registered vector of currently sounding notes and one-cycle note-on pulses for the audio path. It sits between the note RAM read port and the tone generators, alongside the main state handler, which owns the RAM write port.

## Interface
Parameters:
- NOTE_COUNT, 101: number of RAM addresses scanned (0..NOTE_COUNT-1).
- ADDR_W, 7: RAM address width.
- TIME_W, 29: timestamp and counter width.
- CODE_W, 4: note code width. The active vector is 2**CODE_W bits.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- start  in  1  pulse: begin or restart playback.
- stop  in  1  pulse: end playback.
- microSecondCounter  in  TIME_W  running time from the shared timer.
- retrievedNoteData  in  62  RAM read data, valid one cycle after the address.
- noteReadAddress  out  ADDR_W  RAM read address.
- timerReset  out  1  one-cycle pulse to zero the shared timer.
- activeNotes  out  2**CODE_W  bit c set means note code c is sounding.
- noteOnPulse  out  2**CODE_W  one-cycle pulse for each newly active code.
- playing  out  1  high in any state other than IDLE.
- endOfSong  out  1  one-cycle pulse when playback completes.

## Operation
- Word format: [61:58] code; [57:29] start; [28:0] end. An end of 0 means the note is still open. An all-zero word is the end-of-list marker.
- A word is active when start <= t and (end == 0 or t < end), where t is microSecondCounter sampled at the moment the word is evaluated. All comparisons are unsigned, TIME_W bits wide.
- States:
  - IDLE: address 0, outputs cleared. start leads to PRIME and pulses timerReset.
  - PRIME: present address 0 and wait one cycle for the RAM read latency. Always goes to SCAN.
  - SCAN: each cycle, evaluate the returned word, OR its code bit into the accumulator when active, and increment the address.
    - Also track maxEnd (the largest end seen) and openSeen (any word with end == 0).
    - The pass ends on an all-zero word, or after evaluating address NOTE_COUNT-1. Either way, go to COMMIT.
  - COMMIT:
    - activeNotes <= accumulator.
    - noteOnPulse <= accumulator & ~activeNotes.
    - If the pass found at least one word, openSeen == 0, and t >= maxEnd: pulse endOfSong and go to the end action.
    - Otherwise clear the accumulator, maxEnd and openSeen, and go to PRIME.
- End action: clear activeNotes and go to IDLE.
- An empty list (address 0 holds an all-zero word) never ends the song. The block rescans until stopped.
- stop in any state: go to IDLE next cycle and clear activeNotes, noteOnPulse and the accumulator.
- start while playing: pulse timerReset, reset the address to 0, clear the accumulator, and go to PRIME. activeNotes holds until the next COMMIT.
- start and stop in the same cycle: stop wins.
- The block never writes the RAM and does not arbitrate the read port. The state handler must not drive the read address while playing is high.

## Timing
- Reset values: noteReadAddress 0, activeNotes 0, noteOnPulse 0, timerReset 0, playing 0, endOfSong 0, state IDLE.
- RAM read latency is fixed at 1 cycle. In SCAN, the address advances every cycle and the data evaluated belongs to address-1.
- Pass length for k valid words followed by a terminator is 1 (PRIME) + k+1 (SCAN) + 1 (COMMIT) cycles. A full RAM takes NOTE_COUNT+2 cycles.
- timerReset fires in the cycle after start is sampled. The first PRIME follows in the same cycle.
- noteOnPulse and endOfSong are each high for exactly 1 cycle, in the cycle after COMMIT.
- Address wrap: the address never exceeds NOTE_COUNT-1. It returns to 0 in PRIME.

## Configuration
- SCHED_LOOP_EN defined: at end of song, pulse timerReset, clear activeNotes, and go to PRIME so playback loops. endOfSong still pulses on each loop.
- SCHED_LOOP_EN undefined: at end of song, go to IDLE. playing drops in the cycle after the endOfSong pulse.

## Test plan
- Single note: word0 = {4'd3, start 100, end 500}, word1 = 0, start at t=0.
  - At t≈150, activeNotes = 16'h0008 and noteOnPulse pulses bit 3 exactly once.
  - At t >= 500, endOfSong pulses, activeNotes = 0 and playing = 0 (macro undefined).
- Overlap: codes 1 [0,300) and 2 [200,400). At t=250, activeNotes = 16'h0006. At t=350, activeNotes = 16'h0004. No second noteOnPulse for code 2.
- Open note: {4'd5, start 10, end 0}. Bit 5 stays set indefinitely and endOfSong never fires.
- Stop mid-SCAN with 3 words: playing = 0 and activeNotes = 0 on the next cycle. A same-cycle start+stop leaves the block in IDLE.
- Full RAM of non-zero words: the pass takes 103 cycles and the last address read is 100, with no access beyond it.
- Loop (SCHED_LOOP_EN defined): after endOfSong, timerReset pulses and bit 3 re-asserts on the next pass at t≈100.

Source files
------------

// File: rtl/note_playback_scheduler.sv
// Note RAM playback scheduler: scans stored note words once per pass and
// builds the sounding-note vector. Define SCHED_LOOP_EN to loop the song.
module note_playback_scheduler #(
    parameter int NOTE_COUNT = 101,
    parameter int ADDR_W     = 7,
    parameter int TIME_W     = 29,
    parameter int CODE_W     = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    input  logic [TIME_W-1:0]           microSecondCounter,
    input  logic [CODE_W+2*TIME_W-1:0]  retrievedNoteData,
    output logic [ADDR_W-1:0]           noteReadAddress,
    output logic                        timerReset,
    output logic [(2**CODE_W)-1:0]      activeNotes,
    output logic [(2**CODE_W)-1:0]      noteOnPulse,
    output logic                        playing,
    output logic                        endOfSong
);

    localparam int NOTES  = 2**CODE_W;
    localparam int DATA_W = CODE_W + 2*TIME_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NOTE_COUNT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [NOTES-1:0]  NOTE_ONE  = {{(NOTES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME  = 3'd1,
        S_SCAN   = 3'd2,
        S_COMMIT = 3'd3,
        S_END    = 3'd4
    } state_t;

    function automatic logic [CODE_W-1:0] word_code(input logic [DATA_W-1:0] w);
        return w[DATA_W-1 -: CODE_W];
    endfunction

    function automatic logic [TIME_W-1:0] word_start(input logic [DATA_W-1:0] w);
        return w[2*TIME_W-1 -: TIME_W];
    endfunction

    function automatic logic [TIME_W-1:0] word_end(input logic [DATA_W-1:0] w);
        return w[TIME_W-1:0];
    endfunction

    // An open note (end == 0) stays active once its start time is reached.
    function automatic logic word_active(input logic [DATA_W-1:0] w,
                                         input logic [TIME_W-1:0] t);
        return (word_start(w) <= t) &&
               ((word_end(w) == {TIME_W{1'b0}}) || (t < word_end(w)));
    endfunction

    function automatic logic [ADDR_W-1:0] addr_sat_inc(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? a : (a + ADDR_ONE);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   eval_q, eval_d;
    logic [NOTES-1:0]    acc_q, acc_d;
    logic [TIME_W-1:0]   max_end_q, max_end_d;
    logic                open_seen_q, open_seen_d;
    logic                found_q, found_d;
    logic [NOTES-1:0]    active_q, active_d;
    logic [NOTES-1:0]    note_on_q, note_on_d;
    logic                timer_reset_q, timer_reset_d;
    logic                playing_q, playing_d;
    logic                eos_q, eos_d;

    logic                word_nz_s;
    logic                word_act_s;
    logic [TIME_W-1:0]   word_end_s;
    logic [NOTES-1:0]    code_bit_s;
    logic                pass_done_s;

    assign word_nz_s   = |retrievedNoteData;
    assign word_act_s  = word_nz_s && word_active(retrievedNoteData, microSecondCounter);
    assign word_end_s  = word_end(retrievedNoteData);
    assign code_bit_s  = NOTE_ONE << word_code(retrievedNoteData);
    assign pass_done_s = !word_nz_s || (eval_q == LAST_ADDR);

    // Next-state and next-output logic for the scan sequencer.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        eval_d        = eval_q;
        acc_d         = acc_q;
        max_end_d     = max_end_q;
        open_seen_d   = open_seen_q;
        found_d       = found_q;
        active_d      = active_q;
        note_on_d     = {NOTES{1'b0}};
        timer_reset_d = 1'b0;
        eos_d         = 1'b0;

        if (stop) begin
            state_d     = S_IDLE;
            addr_d      = {ADDR_W{1'b0}};
            eval_d      = {ADDR_W{1'b0}};
            acc_d       = {NOTES{1'b0}};
            max_end_d   = {TIME_W{1'b0}};
            open_seen_d = 1'b0;
            found_d     = 1'b0;
            active_d    = {NOTES{1'b0}};
        end else if (start) begin
            // Restart keeps activeNotes until the next commit.
            state_d       = S_PRIME;
            timer_reset_d = 1'b1;
            addr_d        = {ADDR_W{1'b0}};
            eval_d        = {ADDR_W{1'b0}};
            acc_d         = {NOTES{1'b0}};
            max_end_d     = {TIME_W{1'b0}};
            open_seen_d   = 1'b0;
            found_d       = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    addr_d      = {ADDR_W{1'b0}};
                    eval_d      = {ADDR_W{1'b0}};
                    acc_d       = {NOTES{1'b0}};
                    max_end_d   = {TIME_W{1'b0}};
                    open_seen_d = 1'b0;
                    found_d     = 1'b0;
                    active_d    = {NOTES{1'b0}};
                end
                S_PRIME: begin
                    addr_d  = addr_sat_inc(addr_q);
                    eval_d  = {ADDR_W{1'b0}};
                    state_d = S_SCAN;
                end
                S_SCAN: begin
                    // Data on the bus belongs to eval_q (one address behind).
                    if (word_nz_s) begin
                        found_d = 1'b1;
                        if (word_end_s == {TIME_W{1'b0}}) begin
                            open_seen_d = 1'b1;
                        end else if (word_end_s > max_end_q) begin
                            max_end_d = word_end_s;
                        end else begin
                            max_end_d = max_end_q;
                        end
                    end else begin
                        found_d = found_q;
                    end
                    if (word_act_s) begin
                        acc_d = acc_q | code_bit_s;
                    end else begin
                        acc_d = acc_q;
                    end
                    if (pass_done_s) begin
                        state_d = S_COMMIT;
                    end else begin
                        addr_d = addr_sat_inc(addr_q);
                        eval_d = eval_q + ADDR_ONE;
                    end
                end
                S_COMMIT: begin
                    active_d  = acc_q;
                    note_on_d = acc_q & ~active_q;
                    if (found_q && !open_seen_q && (microSecondCounter >= max_end_q)) begin
                        eos_d   = 1'b1;
                        state_d = S_END;
                    end else begin
                        acc_d       = {NOTES{1'b0}};
                        max_end_d   = {TIME_W{1'b0}};
                        open_seen_d = 1'b0;
                        found_d     = 1'b0;
                        addr_d      = {ADDR_W{1'b0}};
                        eval_d      = {ADDR_W{1'b0}};
                        state_d     = S_PRIME;
                    end
                end
                S_END: begin
                    active_d    = {NOTES{1'b0}};
                    acc_d       = {NOTES{1'b0}};
                    max_end_d   = {TIME_W{1'b0}};
                    open_seen_d = 1'b0;
                    found_d     = 1'b0;
                    addr_d      = {ADDR_W{1'b0}};
                    eval_d      = {ADDR_W{1'b0}};
`ifdef SCHED_LOOP_EN
                    timer_reset_d = 1'b1;
                    state_d       = S_PRIME;
`else
                    state_d       = S_IDLE;
`endif
                end
                default: begin
                    state_d     = S_IDLE;
                    addr_d      = {ADDR_W{1'b0}};
                    eval_d      = {ADDR_W{1'b0}};
                    acc_d       = {NOTES{1'b0}};
                    max_end_d   = {TIME_W{1'b0}};
                    open_seen_d = 1'b0;
                    found_d     = 1'b0;
                    active_d    = {NOTES{1'b0}};
                end
            endcase
        end

        playing_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= {ADDR_W{1'b0}};
            eval_q        <= {ADDR_W{1'b0}};
            acc_q         <= {NOTES{1'b0}};
            max_end_q     <= {TIME_W{1'b0}};
            open_seen_q   <= 1'b0;
            found_q       <= 1'b0;
            active_q      <= {NOTES{1'b0}};
            note_on_q     <= {NOTES{1'b0}};
            timer_reset_q <= 1'b0;
            playing_q     <= 1'b0;
            eos_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            eval_q        <= eval_d;
            acc_q         <= acc_d;
            max_end_q     <= max_end_d;
            open_seen_q   <= open_seen_d;
            found_q       <= found_d;
            active_q      <= active_d;
            note_on_q     <= note_on_d;
            timer_reset_q <= timer_reset_d;
            playing_q     <= playing_d;
            eos_q         <= eos_d;
        end
    end

    assign noteReadAddress = addr_q;
    assign timerReset      = timer_reset_q;
    assign activeNotes     = active_q;
    assign noteOnPulse     = note_on_q;
    assign playing         = playing_q;
    assign endOfSong       = eos_q;

endmodule

// File: tb/tb_note_playback_scheduler.sv
// Directed bench for note_playback_scheduler: a one-cycle-latency note RAM model,
// a vector table of steady-state expectations and hand-written corner sequences.
module tb_note_playback_scheduler;

`ifdef SCHED_LOOP_EN
    localparam bit LOOP_MODE = 1'b1;
`else
    localparam bit LOOP_MODE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [28:0] t = 29'd0;
    logic [61:0] rdata = 62'd0;
    logic [6:0]  noteReadAddress;
    logic        timerReset;
    logic [15:0] activeNotes;
    logic [15:0] noteOnPulse;
    logic        playing;
    logic        endOfSong;

    logic [61:0] mem [0:127];
    int checks = 0;
    int errors = 0;
    int on_cnt [16] = '{default: 0};
    int eos_cnt = 0;
    int max_addr = 0;

    note_playback_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .stop               (stop),
        .microSecondCounter (t),
        .retrievedNoteData  (rdata),
        .noteReadAddress    (noteReadAddress),
        .timerReset         (timerReset),
        .activeNotes        (activeNotes),
        .noteOnPulse        (noteOnPulse),
        .playing            (playing),
        .endOfSong          (endOfSong)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[noteReadAddress];

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) if (noteOnPulse[i]) on_cnt[i]++;
            if (endOfSong) eos_cnt++;
            if (int'(noteReadAddress) > max_addr) max_addr = int'(noteReadAddress);
        end
    end

    function automatic logic [61:0] w(input int c, input int s, input int e);
        logic [31:0] cc, ss, ee;
        cc = c; ss = s; ee = e;
        return {cc[3:0], ss[28:0], ee[28:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    task automatic load(input int scen);
        for (int i = 0; i < 128; i++) mem[i] = 62'd0;
        case (scen)
            0: begin mem[0] = w(1, 0, 300); mem[1] = w(2, 200, 400); end
            1: begin mem[0] = w(3, 100, 500); end
            2: begin mem[0] = w(5, 10, 0); end
            3: begin mem[0] = w(1, 0, 0); mem[1] = w(2, 0, 0); mem[2] = w(4, 0, 0); end
            default: begin
                for (int i = 0; i < 128; i++) mem[i] = w(7, 1000, 0);
            end
        endcase
    endtask

    typedef struct {
        int          scen;
        logic [28:0] tv;
        logic [15:0] exp_act;
        logic        exp_play;
    } vec_t;

    vec_t vec [16];

    initial begin
        int cur;
        int n;
        int last_a;
        int eos_snap;
        bit seen;
        bit got;

        vec[0]  = '{0, 29'd50,         16'h0002, 1'b1};
        vec[1]  = '{0, 29'd199,        16'h0002, 1'b1};
        vec[2]  = '{0, 29'd200,        16'h0006, 1'b1};
        vec[3]  = '{0, 29'd250,        16'h0006, 1'b1};
        vec[4]  = '{0, 29'd300,        16'h0004, 1'b1};
        vec[5]  = '{0, 29'd350,        16'h0004, 1'b1};
        vec[6]  = '{0, 29'd400,        16'h0000, LOOP_MODE};
        vec[7]  = '{2, 29'd5,          16'h0000, 1'b1};
        vec[8]  = '{2, 29'd10,         16'h0020, 1'b1};
        vec[9]  = '{2, 29'd20,         16'h0020, 1'b1};
        vec[10] = '{2, 29'h1FFF_FFFF,  16'h0020, 1'b1};
        vec[11] = '{1, 29'd0,          16'h0000, 1'b1};
        vec[12] = '{1, 29'd99,         16'h0000, 1'b1};
        vec[13] = '{1, 29'd100,        16'h0008, 1'b1};
        vec[14] = '{1, 29'd150,        16'h0008, 1'b1};
        vec[15] = '{1, 29'd499,        16'h0008, 1'b1};

        load(0);
        cyc(3);
        chk("rst_addr", 32'(noteReadAddress), 32'd0);
        chk("rst_active", 32'(activeNotes), 32'd0);
        chk("rst_noteon", 32'(noteOnPulse), 32'd0);
        chk("rst_timer", 32'(timerReset), 32'd0);
        chk("rst_playing", 32'(playing), 32'd0);
        chk("rst_eos", 32'(endOfSong), 32'd0);
        reset = 1'b0;
        cyc(2);

        cur = -1;
        for (int k = 0; k < 16; k++) begin
            if (vec[k].scen != cur) begin
                stop = 1'b1;
                cyc(1);
                stop = 1'b0;
                load(vec[k].scen);
                t = vec[k].tv;
                pulse_start();
                cur = vec[k].scen;
            end
            t = vec[k].tv;
            cyc(12);
            chk($sformatf("vec%0d_active", k), 32'(activeNotes), 32'(vec[k].exp_act));
            chk($sformatf("vec%0d_playing", k), 32'(playing), 32'(vec[k].exp_play));
        end
        chk("noteon_cnt_code1", on_cnt[1], 32'd1);
        chk("noteon_cnt_code2", on_cnt[2], 32'd1);
        chk("noteon_cnt_code5", on_cnt[5], 32'd1);
        chk("noteon_cnt_code3", on_cnt[3], 32'd1);
`ifndef SCHED_LOOP_EN
        chk("eos_cnt_after_table", eos_cnt, 32'd1);
`endif

        // Single note reaching its end time.
        t = 29'd500;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc(1);
            if (endOfSong) got = 1'b1;
        end
        chk("single_eos_seen", 32'(got), 32'd1);
        chk("single_eos_playing", 32'(playing), 32'd1);
        cyc(1);
        chk("single_after_eos_active", 32'(activeNotes), 32'd0);
        chk("single_after_eos_eos", 32'(endOfSong), 32'd0);
`ifdef SCHED_LOOP_EN
        chk("loop_timer_reset", 32'(timerReset), 32'd1);
        chk("loop_playing", 32'(playing), 32'd1);
        t = 29'd150;
        cyc(15);
        chk("loop_reassert", 32'(activeNotes), 32'h0008);
`else
        chk("single_after_eos_playing", 32'(playing), 32'd0);
        chk("single_after_eos_timer", 32'(timerReset), 32'd0);
`endif

        // Restart while playing, then stop mid-scan.
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        load(3);
        t = 29'd10;
        pulse_start();
        cyc(15);
        chk("three_active", 32'(activeNotes), 32'h0016);
        pulse_start();
        chk("restart_timer", 32'(timerReset), 32'd1);
        chk("restart_hold_active", 32'(activeNotes), 32'h0016);
        chk("restart_addr", 32'(noteReadAddress), 32'd0);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc(1);
            if (noteReadAddress == 7'd2) got = 1'b1;
        end
        chk("midscan_reached", 32'(got), 32'd1);
        chk("restart_timer_once", 32'(timerReset), 32'd0);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        chk("stop_playing", 32'(playing), 32'd0);
        chk("stop_active", 32'(activeNotes), 32'd0);
        chk("stop_noteon", 32'(noteOnPulse), 32'd0);
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_idle_playing", 32'(playing), 32'd0);
        chk("startstop_idle_timer", 32'(timerReset), 32'd0);
        pulse_start();
        cyc(3);
        start = 1'b1;
        stop = 1'b1;
        cyc(1);
        start = 1'b0;
        stop = 1'b0;
        chk("startstop_play_playing", 32'(playing), 32'd0);

        // Full RAM of open notes: pass length and address bound.
        load(4);
        t = 29'd0;
        pulse_start();
        chk("full_prime_timer", 32'(timerReset), 32'd1);
        chk("full_prime_addr", 32'(noteReadAddress), 32'd0);
        n = 0;
        seen = 1'b0;
        last_a = 0;
        for (int i = 0; i < 300; i++) begin
            cyc(1);
            n++;
            if (noteReadAddress != 7'd0) begin
                seen = 1'b1;
                last_a = int'(noteReadAddress);
            end else if (seen) begin
                break;
            end
        end
        chk("full_pass_len", n, 32'd103);
        chk("full_last_addr", last_a, 32'd100);
        eos_snap = eos_cnt;
        t = 29'd2000;
        cyc(250);
        chk("full_active", 32'(activeNotes), 32'h0080);
        chk("full_no_eos", eos_cnt - eos_snap, 32'd0);
        chk("max_addr", max_addr, 32'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
